// File: rtl/mem_stage_access_ctrl.sv
// M-stage data memory / IO access controller.
// Multi-cycle req/ack handshake with stall, misalign and timeout.
module mem_stage_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0000_7F00),
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic              rdata_valid,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              io_req,
  output logic              dev_we,
  output logic [3:0]        dev_be,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [31:0]       dev_wdata,
  input  logic              mem_ack,
  input  logic              io_ack,
  input  logic [31:0]       mem_rdata,
  input  logic [31:0]       io_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    IO_WAIT  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        lo_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic        mis;
  logic        is_io;
  logic        accept;
  logic        hit_ack;
  logic        expire;
  logic        to_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ack_word;
  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;

  assign mis = (req_size == 2'b01 && req_addr[0])
            || (req_size[1] && req_addr[1:0] != 2'b00);
  assign is_io  = (req_addr >= IO_BASE);
  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  assign dev_we    = we_q;
  assign dev_be    = be_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;

  // byte-enable and store-lane decode of the incoming request
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    unique case (1'b1)
      req_size == 2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      req_size == 2'b01: begin
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
    endcase
  end

  // lane select and extension of the acked read word
  always_comb begin
    ack_word = (state_q == IO_WAIT) ? io_rdata : mem_rdata;
    shifted  = ack_word >> {lo_q, 3'b000};
    lane_b   = shifted[7:0];
    lane_h   = lo_q[1] ? ack_word[31:16] : ack_word[15:0];
    load_ext = ack_word;
    unique case (1'b1)
      size_q == 2'b00:
        load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
      size_q == 2'b01:
        load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
      default:
        load_ext = ack_word;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    done        = 1'b0;
    rdata_valid = 1'b0;
    rdata       = '0;
    misalign    = 1'b0;
    bus_err     = 1'b0;
    mem_req     = 1'b0;
    io_req      = 1'b0;
    accept      = 1'b0;
    hit_ack     = 1'b0;
    expire      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !reset) begin
          if (mis) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            accept  = 1'b1;
            state_d = is_io ? IO_WAIT : MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack) begin
          hit_ack = 1'b1;
          state_d = DONE;
        end else if (to_hit) begin
          expire  = 1'b1;
          state_d = DONE;
        end
      end
      IO_WAIT: begin
        io_req = 1'b1;
        stall  = 1'b1;
        if (io_ack) begin
          hit_ack = 1'b1;
          state_d = DONE;
        end else if (to_hit) begin
          expire  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        rdata_valid = !we_q && !err_q;
        bus_err     = err_q;
        rdata       = rdata_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // request capture, wait counter and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      lo_q     <= 2'b00;
      be_q     <= 4'b0000;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      we_q     <= req_we;
      size_q   <= req_size;
      signed_q <= req_signed;
      lo_q     <= req_addr[1:0];
      be_q     <= be_d;
      addr_q   <= {req_addr[ADDR_W-1:2], 2'b00};
      wdata_q  <= wdata_d;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (hit_ack) begin
      rdata_q <= we_q ? 32'h0 : load_ext;
      err_q   <= 1'b0;
    end else if (expire) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end else if (state_q == MEM_WAIT
              || state_q == IO_WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Bench for mem_stage_access_ctrl.
// Directed steps, scoreboard queue of expected completions.
module tb_mem_stage_access_ctrl;

  localparam int TO = 16;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        io_req;
  logic        dev_we;
  logic [3:0]  dev_be;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic        mem_ack;
  logic        io_ack;
  logic [31:0] mem_rdata;
  logic [31:0] io_rdata;

  typedef struct {
    logic [31:0] rd;
    logic        rv;
    logic        be;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  mem_stage_access_ctrl #(
    .ADDR_W (32),
    .IO_BASE(32'h0000_7F00),
    .TIMEOUT(TO),
    .CNT_W  (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .io_req     (io_req),
    .dev_we     (dev_we),
    .dev_be     (dev_be),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .mem_ack    (mem_ack),
    .io_ack     (io_ack),
    .mem_rdata  (mem_rdata),
    .io_rdata   (io_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h",
                tag, obs, exp);
  endtask

  // one full transaction; ack_after<0 means never ack
  task automatic do_req(
    input string       nm,
    input logic        we,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic        io,
    input int          ack_after,
    input logic [31:0] rw,
    input logic [3:0]  ebe,
    input logic [31:0] ewd,
    input logic [31:0] erd
  );
    exp_t e;
    exp_t g;
    int   exp_done;
    int   nreq;
    int   nother;
    bit   got;
    logic tgt;
    logic oth;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    mem_ack    = 1'b0;
    io_ack     = 1'b0;
    #1;
    chk({nm, "_stall0"}, 32'(stall), 32'd1);
    chk({nm, "_mis0"}, 32'(misalign), 32'd0);
    e.be = (ack_after < 0);
    e.rv = !we && !e.be;
    e.rd = e.be ? 32'h0 : erd;
    sb.push_back(e);
    exp_done = (ack_after < 0) ? TO + 1 : ack_after + 2;
    nreq   = 0;
    nother = 0;
    got    = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (io) begin
        io_ack    = (c == ack_after + 1);
        io_rdata  = rw;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end else begin
        mem_ack   = (c == ack_after + 1);
        mem_rdata = rw;
        io_ack    = 1'b1;
        io_rdata  = 32'hBAD0_BAD0;
      end
      #1;
      tgt = io ? io_req : mem_req;
      oth = io ? mem_req : io_req;
      if (tgt) nreq++;
      if (oth) nother++;
      if (c == 1) begin
        chk({nm, "_be"}, 32'(dev_be), 32'(ebe));
        chk({nm, "_addr"}, dev_addr,
            {addr[31:2], 2'b00});
        chk({nm, "_wdata"}, dev_wdata, ewd);
        chk({nm, "_we"}, 32'(dev_we), 32'(we));
        chk({nm, "_stall1"}, 32'(stall), 32'd1);
      end
      if (done) begin
        got = 1'b1;
        chk({nm, "_cyc"}, c, exp_done);
        chk({nm, "_stall_d"}, 32'(stall), 32'd0);
        if (sb.size() > 0) begin
          g = sb.pop_front();
          chk({nm, "_rdata"}, rdata, g.rd);
          chk({nm, "_rvalid"}, 32'(rdata_valid),
              32'(g.rv));
          chk({nm, "_buserr"}, 32'(bus_err),
              32'(g.be));
        end
      end
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_nreq"}, nreq, exp_done - 1);
    chk({nm, "_nother"}, nother, 0);
    @(negedge clk);
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    io_ack    = 1'b0;
    #1;
    chk({nm, "_post_done"}, 32'(done), 32'd0);
    chk({nm, "_post_req"},
        32'({mem_req, io_req}), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ack    = 1'b0;
    io_ack     = 1'b0;
    mem_rdata  = '0;
    io_rdata   = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_outs",
        32'({stall, done, rdata_valid, misalign,
             bus_err, mem_req, io_req, dev_we}),
        32'd0);
    chk("rst_be", 32'(dev_be), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", dev_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // store word, ack after 2 wait cycles
    do_req("sw", 1'b1, 2'b10, 1'b0, 32'h10,
           32'hDEAD_BEEF, 1'b0, 2, 32'h0,
           4'b1111, 32'hDEAD_BEEF, 32'h0);

    // load byte signed / unsigned, immediate ack
    do_req("lb", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,
           1'b0, 0, 32'h80FF_1234, 4'b1000,
           32'h0, 32'hFFFF_FF80);
    do_req("lbu", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,
           1'b0, 0, 32'h80FF_1234, 4'b1000,
           32'h0, 32'h0000_0080);

    // load half signed from IO space
    do_req("lh_io", 1'b0, 2'b01, 1'b1, 32'h7F02,
           32'h0, 1'b1, 1, 32'hABCD_0001, 4'b1100,
           32'h0, 32'hFFFF_ABCD);

    // load half unsigned, low lane, mem
    do_req("lhu", 1'b0, 2'b01, 1'b0, 32'h7EFC,
           32'h0, 1'b0, 0, 32'h1234_9876, 4'b0011,
           32'h0, 32'h0000_9876);

    // misaligned store half
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b01;
    req_addr  = 32'h5;
    req_wdata = 32'h1234;
    #1;
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_stall", 32'(stall), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("mis_one", 32'(misalign), 32'd0);
    chk("mis_noreq", 32'({mem_req, io_req}), 32'd0);

    // misaligned word
    @(negedge clk);
    req_valid = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h12;
    #1;
    chk("misw_pulse", 32'(misalign), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("misw_noreq", 32'({mem_req, io_req}), 32'd0);

    // store byte lane replication
    do_req("sb", 1'b1, 2'b00, 1'b0, 32'h6,
           32'h0000_00A5, 1'b0, 0, 32'h0, 4'b0100,
           32'hA5A5_A5A5, 32'h0);

    // store half lane replication, IO
    do_req("sh_io", 1'b1, 2'b01, 1'b0, 32'h7F10,
           32'hFFFF_5AC3, 1'b1, 3, 32'h0, 4'b0011,
           32'h5AC3_5AC3, 32'h0);

    // timeout and ack on the last wait cycle
    do_req("tmo", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0,
           1'b0, -1, 32'h1111_2222, 4'b1111,
           32'h0, 32'h0);
    do_req("ack16", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0,
           1'b0, TO - 1, 32'h1111_2222, 4'b1111,
           32'h0, 32'h1111_2222);
    do_req("tmo_io", 1'b1, 2'b10, 1'b0, 32'h8000,
           32'h5, 1'b1, -1, 32'h0, 4'b1111,
           32'h5, 32'h0);

    // reset during MEM_WAIT
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h20;
    req_wdata = 32'h0BAD_F00D;
    mem_ack   = 1'b0;
    io_ack    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rw_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rw_req_drop", 32'(mem_req), 32'd0);
    chk("rw_stall_drop", 32'(stall), 32'd0);
    chk("rw_done", 32'(done), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rw_nodone",
          32'({done, mem_req, stall}), 32'd0);
    end

    // fresh request after reset
    do_req("post_rst", 1'b0, 2'b10, 1'b0, 32'h24,
           32'h0, 1'b0, 1, 32'hCAFE_F00D, 4'b1111,
           32'h0, 32'hCAFE_F00D);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_access_ctrl.md
Name: mem_stage_access_ctrl

Overview:
Parametrised successor to the pipeline M-stage memory control. Decodes address into data-memory or IO space. Generates byte enables and load extension for byte, half and word accesses. Unlike the single-cycle enable logic it replaces, it runs a multi-cycle req/ack handshake with either target, stalls the pipeline until completion, and flags misaligned accesses and bus timeouts. Sits between M-stage pipeline registers and the DM/IO bus.

Parameters:
ADDR_W, 32, address width
IO_BASE, 32'h0000_7F00, addresses >= IO_BASE go to IO, below go to data memory
TIMEOUT, 16, wait cycles before bus error; 0 disables the timeout
CNT_W, 5, timeout counter width, must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  M-stage instruction is a load/store; held stable while stall=1
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_signed  in  1  sign-extend loaded byte/half
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
stall  out  1  freeze pipeline
done  out  1  one-cycle completion pulse
rdata_valid  out  1  load data valid (with done)
rdata  out  32  extended load result
misalign  out  1  one-cycle misaligned-access pulse
bus_err  out  1  one-cycle timeout pulse
mem_req / io_req  out  1  target request, level until ack
dev_we  out  1  write strobe qualifier
dev_be  out  4  byte enables
dev_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
dev_wdata  out  32  lane-replicated store data
mem_ack / io_ack  in  1  target completion, sampled only in matching wait state
mem_rdata / io_rdata  in  32  read word, valid with ack

Behaviour:
- States: IDLE, MEM_WAIT, IO_WAIT, DONE. Reset forces IDLE immediately.
- Reset values: all outputs 0; request registers cleared. An in-flight request is dropped with no done pulse.
- IDLE:
  - Alignment check: half with addr[0]=1, or word/reserved with addr[1:0]!=0, is misaligned. It produces misalign=1 for that cycle, stall=0, no device request, and the state stays IDLE.
  - Aligned request: stall=1 combinationally in the same cycle. Request fields are registered. Next state is MEM_WAIT if addr < IO_BASE (unsigned), else IO_WAIT.
- WAIT states:
  - The matching *_req is 1. dev_* are driven from registers. stall=1.
  - Matching ack: capture rdata, go DONE.
  - Ack from the non-selected target is ignored.
  - Timeout counter clears on entry and increments each wait cycle. When counter==TIMEOUT-1 and no ack: bus_err=1 next cycle in DONE, rdata=0, rdata_valid=0. Ack in that same cycle wins over timeout.
- DONE: done=1, stall=0, rdata_valid=!we & !err. Next state is always IDLE, so a held instruction is never re-issued.
- Minimum latency: request cycle 0, req high cycle 1, ack in cycle 1, done in cycle 2 (3 cycles stalled-or-completing).
- Byte enables (registered with request):
  - byte: 1<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
  - Driven for loads too, as information.
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- Load extension: select lane by addr[1:0] (byte) or addr[1] (half), right-justify, then sign- or zero-extend per req_signed. Word passes through.
- dev_we=req_we registered. No *_req ever asserted while the state is IDLE or DONE.

Test Plan:
- Store word addr 0x10, wdata 0xDEADBEEF, mem_ack after 2 wait cycles -> mem_req high 3 cycles, dev_be=1111, dev_addr=0x10, done at cycle 4, rdata_valid=0.
- Load byte signed addr 0x13, mem_rdata 0x80FF_1234 acked immediately -> rdata=0xFFFF_FF80; repeat unsigned -> 0x0000_0080.
- Load half addr 0x7F02 (IO), io_rdata 0xABCD_0001 -> io_req used, mem_req never 1, rdata signed=0xFFFF_ABCD.
- Store half addr 0x5 -> misalign pulse 1 cycle, stall=0, no req. Store byte addr 0x6, wdata 0x000000A5 -> dev_be=0100, dev_wdata=0xA5A5A5A5.
- TIMEOUT=16, no ack -> bus_err pulse on cycle 17 after request, rdata=0. Ack arriving exactly on the 16th wait cycle -> normal done, no bus_err.
- Assert reset during MEM_WAIT -> mem_req, stall drop same cycle, no done. After release, a new request completes normally.
